// File: rtl/dac_ad53x8_serial.sv
// Serial-interface model of an AD53x8-style octal DAC register file.
// A 16-bit SYNC_b-framed word is shifted in on SCLK and executed on its 16th bit.
module dac_ad53x8_serial #(
   parameter int N_CH   = 8,
   parameter int DATA_W = 10
) (
   input  logic                     SCLK,
   input  logic                     RST,
   input  logic                     SYNC_b,
   input  logic                     DIN,
   input  logic                     LDAC_b,
   output logic [N_CH*DATA_W-1:0]   VOUT,
   output logic [N_CH-1:0]          PD,
   output logic [1:0]               GAIN,
   output logic [1:0]               BUF,
   output logic [1:0]               VDD_REF,
   output logic                     UPDATE,
   output logic                     FRAME_ERR
);

   // state | meaning
   // IDLE  | waiting for SYNC_b sampled low
   // SHIFT | capturing bits 15..0, count = bits captured so far
   // HOLD  | frame executed, waiting for SYNC_b high; extra bits ignored

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_LOW    = 2'b00;
   localparam logic [1:0] MODE_HIGH   = 2'b01;
   localparam logic [1:0] MODE_SINGLE = 2'b10;
   localparam logic [3:0] N_CH_L      = 4'(N_CH);

   state_t              state_q, state_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [14:0]         sr_q, sr_d;
   logic [DATA_W-1:0]   in_q  [N_CH];
   logic [DATA_W-1:0]   in_d  [N_CH];
   logic [DATA_W-1:0]   dac_q [N_CH];
   logic [DATA_W-1:0]   dac_d [N_CH];
   logic [N_CH-1:0]     pd_q, pd_d;
   logic [1:0]          gain_q, gain_d;
   logic [1:0]          bufc_q, bufc_d;
   logic [1:0]          vref_q, vref_d;
   logic [1:0]          mode_q, mode_d;
   logic                upd_q, upd_d;
   logic                ferr_q, ferr_d;

   logic [15:0]         w;
   logic [2:0]          addr;
   logic                exec;
   logic                load;

   always_comb begin
      w       = {sr_q, DIN};
      addr    = w[14:12];
      exec    = 1'b0;
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      in_d    = in_q;
      dac_d   = dac_q;
      pd_d    = pd_q;
      gain_d  = gain_q;
      bufc_d  = bufc_q;
      vref_d  = vref_q;
      mode_d  = mode_q;
      upd_d   = 1'b0;
      ferr_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!SYNC_b) begin
               sr_d    = {sr_q[13:0], DIN};
               cnt_d   = 5'd1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (SYNC_b) begin
               state_d = ST_IDLE;
               cnt_d   = 5'd0;
               ferr_d  = 1'b1;
            end else begin
               sr_d  = {sr_q[13:0], DIN};
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd15) begin
                  exec    = 1'b1;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (SYNC_b) begin
               state_d = ST_IDLE;
               cnt_d   = 5'd0;
            end else if (cnt_q == 5'd16) begin
               ferr_d = 1'b1;
               cnt_d  = 5'd17;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
         end
      endcase

      // Loads copy the pre-edge input registers; a frame executed on the
      // same edge is therefore only visible at the following load.
      load = (mode_q == MODE_LOW) || !LDAC_b || (mode_q == MODE_SINGLE);
      if (load) begin
         dac_d = in_q;
         upd_d = 1'b1;
         if (mode_q == MODE_SINGLE) mode_d = MODE_HIGH;
      end

      if (exec) begin
         if (!w[15]) begin
            if ({1'b0, addr} >= N_CH_L) begin
               ferr_d = 1'b1;
            end else begin
               for (int i = 0; i < N_CH; i++) begin
                  if ({1'b0, addr} == 4'(i)) in_d[i] = w[11 -: DATA_W];
               end
            end
         end else begin
            case (w[14:13])
               2'b00: begin
                  vref_d = w[1:0];
                  bufc_d = w[3:2];
                  gain_d = w[5:4];
               end
               2'b01: begin
                  if (w[1:0] != 2'b11) mode_d = w[1:0];
               end
               2'b10: pd_d = w[N_CH-1:0];
               default: begin
                  for (int i = 0; i < N_CH; i++) begin
                     in_d[i]  = '0;
                     dac_d[i] = '0;
                  end
                  upd_d = 1'b0;
                  if (w[12]) begin
                     gain_d = 2'b00;
                     bufc_d = 2'b00;
                     vref_d = 2'b00;
                     pd_d   = '0;
                     mode_d = MODE_HIGH;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge SCLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= 5'd0;
         sr_q    <= '0;
         in_q    <= '{default: '0};
         dac_q   <= '{default: '0};
         pd_q    <= '0;
         gain_q  <= 2'b00;
         bufc_q  <= 2'b00;
         vref_q  <= 2'b00;
         mode_q  <= MODE_HIGH;
         upd_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         in_q    <= in_d;
         dac_q   <= dac_d;
         pd_q    <= pd_d;
         gain_q  <= gain_d;
         bufc_q  <= bufc_d;
         vref_q  <= vref_d;
         mode_q  <= mode_d;
         upd_q   <= upd_d;
         ferr_q  <= ferr_d;
      end
   end

   // Powered-down channels read zero but keep their DAC code.
   always_comb begin
      VOUT = '0;
      for (int i = 0; i < N_CH; i++) begin
         VOUT[i*DATA_W +: DATA_W] = pd_q[i] ? '0 : dac_q[i];
      end
   end

   assign PD        = pd_q;
   assign GAIN      = gain_q;
   assign BUF       = bufc_q;
   assign VDD_REF   = vref_q;
   assign UPDATE    = upd_q;
   assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_dac_ad53x8_serial.sv
// Bench for dac_ad53x8_serial: directed scenarios then random frames, checked
// against a frame-level model of the register file.
module tb_dac_ad53x8_serial;

   localparam int M_LOW    = 0;
   localparam int M_HIGH   = 1;
   localparam int M_SINGLE = 2;

   logic        SCLK = 1'b0;
   logic        RST, SYNC_b, DIN, LDAC_b;
   logic [79:0] VOUT;
   logic [7:0]  PD;
   logic [1:0]  GAIN, BUF, VDD_REF;
   logic        UPDATE, FRAME_ERR;
   logic [47:0] VOUT2;
   logic [3:0]  PD2;
   logic [1:0]  GAIN2, BUF2, VREF2;
   logic        UPDATE2, FERR2;

   dac_ad53x8_serial dut (
      .SCLK(SCLK), .RST(RST), .SYNC_b(SYNC_b), .DIN(DIN), .LDAC_b(LDAC_b),
      .VOUT(VOUT), .PD(PD), .GAIN(GAIN), .BUF(BUF), .VDD_REF(VDD_REF),
      .UPDATE(UPDATE), .FRAME_ERR(FRAME_ERR)
   );

   dac_ad53x8_serial #(.N_CH(4), .DATA_W(12)) dut2 (
      .SCLK(SCLK), .RST(RST), .SYNC_b(SYNC_b), .DIN(DIN), .LDAC_b(LDAC_b),
      .VOUT(VOUT2), .PD(PD2), .GAIN(GAIN2), .BUF(BUF2), .VDD_REF(VREF2),
      .UPDATE(UPDATE2), .FRAME_ERR(FERR2)
   );

   always #5 SCLK = ~SCLK;

   logic [9:0]  in_m  [8];
   logic [9:0]  dac_m [8];
   logic [7:0]  pd_m;
   logic [1:0]  gain_m, buf_m, vref_m;
   int          mode_m;

   int          n_vec, n_err;
   int          upd_seen, ferr_seen, upd2_seen, ferr2_seen;
   logic [79:0] v16, v17;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [79:0] exp_vout();
      logic [79:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) if (!pd_m[i]) r[i*10 +: 10] = dac_m[i];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         in_m[i]  = '0;
         dac_m[i] = '0;
      end
      pd_m = '0; gain_m = '0; buf_m = '0; vref_m = '0;
      mode_m = M_HIGH;
   endtask

   task automatic clear_seen();
      upd_seen = 0; ferr_seen = 0; upd2_seen = 0; ferr2_seen = 0;
   endtask

   task automatic step(input logic s, input logic d, input logic l);
      SYNC_b = s; DIN = d; LDAC_b = l;
      @(posedge SCLK); #1;
      if (UPDATE)    upd_seen++;
      if (FRAME_ERR) ferr_seen++;
      if (UPDATE2)   upd2_seen++;
      if (FERR2)     ferr2_seen++;
   endtask

   task automatic check_all(input string tag, input int e_upd, input int e_ferr);
      chk({tag, ":vout"}, 128'(VOUT), 128'(exp_vout()));
      chk({tag, ":pd"}, 128'(PD), 128'(pd_m));
      chk({tag, ":gain"}, 128'(GAIN), 128'(gain_m));
      chk({tag, ":buf"}, 128'(BUF), 128'(buf_m));
      chk({tag, ":vref"}, 128'(VDD_REF), 128'(vref_m));
      chk({tag, ":upd_cnt"}, 128'(upd_seen), 128'(e_upd));
      chk({tag, ":ferr_cnt"}, 128'(ferr_seen), 128'(e_ferr));
   endtask

   // Applies a complete word to the model; returns 1 for a clear command.
   task automatic apply_word(input logic [15:0] w, output bit was_clr);
      was_clr = 0;
      if (!w[15]) begin
         in_m[w[14:12]] = w[11:2];
      end else begin
         case (w[14:13])
            2'b00: begin vref_m = w[1:0]; buf_m = w[3:2]; gain_m = w[5:4]; end
            2'b01: if (w[1:0] != 2'b11) mode_m = int'(w[1:0]);
            2'b10: pd_m = w[7:0];
            default: begin
               was_clr = 1;
               for (int i = 0; i < 8; i++) begin
                  in_m[i]  = '0;
                  dac_m[i] = '0;
               end
               if (w[12]) begin
                  pd_m = '0; gain_m = '0; buf_m = '0; vref_m = '0;
                  mode_m = M_HIGH;
               end
            end
         endcase
      end
   endtask

   // Frame of nbits edges with SYNC_b low, then two edges with SYNC_b high.
   task automatic send_frame(input string tag, input logic [15:0] w, input int nbits);
      int total, pre, post, e_upd, e_ferr;
      bit was_clr;
      clear_seen();
      for (int k = 0; k < nbits; k++) begin
         step(1'b0, (k < 16) ? w[15-k] : 1'($urandom_range(0, 1)), 1'b1);
         if (k == 15) v16 = VOUT;
         if (k == 16) v17 = VOUT;
      end
      step(1'b1, 1'b0, 1'b1);
      if (nbits == 16) v17 = VOUT;
      step(1'b1, 1'b0, 1'b1);
      total = nbits + 2;
      if (nbits < 16) begin
         e_ferr = 1;
         e_upd  = (mode_m == M_LOW) ? total : 0;
         if (mode_m == M_LOW) dac_m = in_m;
      end else begin
         e_ferr = (nbits > 16) ? 1 : 0;
         pre    = (mode_m == M_LOW) ? 16 : 0;
         if (pre > 0) dac_m = in_m;
         apply_word(w, was_clr);
         if (was_clr && pre > 0) pre--;
         if (mode_m == M_LOW) post = total - 16;
         else if (mode_m == M_SINGLE) post = 1;
         else post = 0;
         if (mode_m == M_SINGLE) mode_m = M_HIGH;
         if (post > 0) dac_m = in_m;
         e_upd = pre + post;
      end
      check_all(tag, e_upd, e_ferr);
   endtask

   task automatic pulse_ldac(input string tag);
      clear_seen();
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      dac_m = in_m;
      check_all(tag, (mode_m == M_LOW) ? 3 : 1, 0);
   endtask

   task automatic idle_check(input string tag, input int n);
      clear_seen();
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b1);
      if (mode_m == M_LOW) dac_m = in_m;
      check_all(tag, (mode_m == M_LOW) ? n : 0, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w;
      logic [47:0] e2;
      int r, nb;
      n_vec = 0; n_err = 0;
      v16 = '0; v17 = '0;
      RST = 1'b1; SYNC_b = 1'b1; DIN = 1'b0; LDAC_b = 1'b1;
      model_reset();
      clear_seen();
      #23;
      chk("rst:vout", 128'(VOUT), 128'(0));
      chk("rst:pd", 128'(PD), 128'(0));
      chk("rst:upd", 128'(UPDATE), 128'(0));
      chk("rst:ferr", 128'(FRAME_ERR), 128'(0));
      @(posedge SCLK); #1;
      RST = 1'b0;
      idle_check("post_rst", 3);

      send_frame("wr_ch2", 16'h2554, 16);
      pulse_ldac("ldac_ch2");
      chk("ch2_code", 128'(VOUT[29:20]), 128'(10'h155));

      send_frame("mode_low", 16'hA000, 16);
      send_frame("wr_ch7", 16'h7FFC, 16);
      chk("ch7_exec_edge", 128'(v16[79:70]), 128'(0));
      chk("ch7_next_edge", 128'(v17[79:70]), 128'(10'h3FF));

      send_frame("abort9", 16'h1234, 9);
      send_frame("long17", 16'h3A5C, 17);

      send_frame("mode_high", 16'hA001, 16);
      send_frame("wr_ch0", 16'h0AA8, 16);
      pulse_ldac("ldac_ch0");
      send_frame("pd81", 16'hC081, 16);
      chk("pd81_word", 128'(PD), 128'(8'h81));
      send_frame("pd00", 16'hC000, 16);

      send_frame("ref_all", 16'h803F, 16);
      send_frame("wr_ch4", 16'h4CCC, 16);
      send_frame("mode_single", 16'hA002, 16);
      send_frame("wr_ch4_hold", 16'h4000, 16);
      idle_check("high_idle", 4);

      // Reset in the middle of a frame clears everything at once.
      for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b1);
      RST = 1'b1;
      #1;
      chk("midrst:vout", 128'(VOUT), 128'(0));
      chk("midrst:gain", 128'(GAIN), 128'(0));
      chk("midrst:pd", 128'(PD), 128'(0));
      chk("midrst:upd", 128'(UPDATE), 128'(0));
      chk("midrst:ferr", 128'(FRAME_ERR), 128'(0));
      SYNC_b = 1'b1;
      @(posedge SCLK); #1;
      RST = 1'b0;
      model_reset();
      idle_check("midrst_idle", 3);

      for (int it = 0; it < 250; it++) begin
         r = $urandom_range(0, 99);
         nb = 16;
         if (r < 40) begin
            w = {1'b0, 3'($urandom_range(0, 7)), 12'($urandom)};
            if ($urandom_range(0, 4) == 0) nb = 16 + $urandom_range(1, 3);
            send_frame("rnd_wr", w, nb);
         end else if (r < 50) begin
            send_frame("rnd_ref", {3'b100, 13'($urandom)}, 16);
         end else if (r < 62) begin
            send_frame("rnd_mode", {3'b101, 11'($urandom), 2'($urandom_range(0, 3))}, 16);
         end else if (r < 72) begin
            send_frame("rnd_pd", {3'b110, 13'($urandom)}, 16);
         end else if (r < 76) begin
            send_frame("rnd_clr", {3'b111, 13'($urandom)}, 16);
         end else if (r < 86) begin
            send_frame("rnd_abort", 16'($urandom), $urandom_range(1, 15));
         end else if (r < 94) begin
            pulse_ldac("rnd_ldac");
         end else begin
            idle_check("rnd_idle", $urandom_range(1, 5));
         end
      end

      // Narrower, wider-code instance: out-of-range address and 12-bit data.
      RST = 1'b1;
      @(posedge SCLK); #1;
      RST = 1'b0;
      model_reset();
      send_frame("d2_a5", 16'h5123, 16);
      chk("d2_a5_ferr", 128'(ferr2_seen), 128'(1));
      chk("d2_a5_vout", 128'(VOUT2), 128'(0));
      send_frame("d2_a3", 16'h3ABC, 16);
      chk("d2_a3_ferr", 128'(ferr2_seen), 128'(0));
      pulse_ldac("d2_ldac");
      e2 = '0;
      e2[47:36] = 12'hABC;
      chk("d2_upd", 128'(upd2_seen), 128'(1));
      chk("d2_vout", 128'(VOUT2), 128'(e2));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
